// File: rtl/display_port_pkg.sv
// Shared register map and status layout for the display port peripheral.
// The datapath address decoder and software headers use the same constants.
package display_port_pkg;

    localparam logic [31:0] DATA_OFFSET   = 32'd0;
    localparam logic [31:0] STATUS_OFFSET = 32'd4;

    localparam int BUSY_BIT    = 0;
    localparam int PENDING_BIT = 1;
    localparam int OVERRUN_BIT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic pending_valid,
                                                input logic overrun);
        logic [31:0] w;
        w              = '0;
        w[BUSY_BIT]    = busy;
        w[PENDING_BIT] = pending_valid;
        w[OVERRUN_BIT] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/display_port_hold_timer.sv
// Loadable down-counter that measures how long the current value has been shown.
// It stops at zero; a load always takes priority over the decrement.
module hold_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired,
    output logic             running
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);
    assign running = (count_q != '0);

endmodule

// File: rtl/display_port.sv
// Memory-mapped 7-segment display port: holds each stored byte for HOLD_CYCLES
// cycles and buffers one pending byte (latest wins) while a hold is in progress.
module display_port
    import display_port_pkg::*;
#(
    parameter logic [31:0] PORT_ADDRESS = 32'h1001_0044,
    parameter int          HOLD_CYCLES  = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  DisplayValue,
    output logic        Busy,
    output logic        Overrun
);

    localparam int                CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  display_q, display_d;
    logic [7:0]  pending_q, pending_d;
    logic        pending_valid_q, pending_valid_d;
    logic        overrun_q, overrun_d;

    logic        data_sel, status_sel;
    logic        data_wr, status_wr;
    logic        timer_load, timer_expired, timer_running;
    logic        overrun_set;
    logic        unused_wdata_bits;

    assign data_sel   = (Address == PORT_ADDRESS + DATA_OFFSET);
    assign status_sel = (Address == PORT_ADDRESS + STATUS_OFFSET);
    assign data_wr    = MemWrite && data_sel;
    assign status_wr  = MemWrite && status_sel;

    assign unused_wdata_bits = &{1'b0, WriteData[31:8]};

    hold_timer #(
        .WIDTH (CNT_W)
    ) u_hold_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (RELOAD),
        .expired    (timer_expired),
        .running    (timer_running)
    );

    always_comb begin
        state_d         = state_q;
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        timer_load      = 1'b0;
        overrun_set     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_wr) begin
                    display_d  = WriteData[7:0];
                    timer_load = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_expired) begin
                    // Expiry: promote the buffered byte first, else accept a
                    // coincident write directly, else the display goes idle.
                    if (pending_valid_q) begin
                        display_d  = pending_q;
                        timer_load = 1'b1;
                        if (data_wr) begin
                            pending_d = WriteData[7:0];
                        end else begin
                            pending_valid_d = 1'b0;
                        end
                    end else if (data_wr) begin
                        display_d  = WriteData[7:0];
                        timer_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (data_wr && timer_running) begin
                    pending_d       = WriteData[7:0];
                    pending_valid_d = 1'b1;
                    overrun_set     = pending_valid_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (status_wr && WriteData[OVERRUN_BIT]) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            overrun_q       <= overrun_d;
        end
    end

    assign DisplayValue = display_q;
    assign Busy         = (state_q == ST_HOLD);
    assign Overrun      = overrun_q;

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            if (data_sel) begin
                ReadData = {24'b0, display_q};
            end else if (status_sel) begin
                ReadData = status_word(Busy, pending_valid_q, overrun_q);
            end
        end
    end

endmodule

// File: tb/tb_display_port.sv
// Self-checking bench for display_port: directed scenarios followed by random
// bus traffic, all compared against a time-based behavioural model.
module tb_display_port;

    localparam logic [31:0] PA = 32'h1001_0044;
    localparam int          H  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  DisplayValue;
    logic        Busy;
    logic        Overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: what is shown, what is waiting, and for how many cycles the
    // current value has already been on display.
    logic [7:0] m_disp;
    logic [7:0] m_pend;
    logic       m_pv;
    logic       m_ovr;
    logic       m_busy;
    int         m_shown;

    always #5 clk = ~clk;

    display_port #(
        .PORT_ADDRESS (PA),
        .HOLD_CYCLES  (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Address      (Address),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .DisplayValue (DisplayValue),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic mw,
                              input logic [31:0] addr, input logic [31:0] wd);
        logic wr_d;
        logic wr_s;
        logic set_ovr;
        wr_d    = mw && (addr == PA);
        wr_s    = mw && (addr == PA + 32'd4);
        set_ovr = 1'b0;
        if (rst) begin
            m_disp = '0; m_pend = '0; m_pv = 1'b0; m_ovr = 1'b0;
            m_busy = 1'b0; m_shown = 0;
            return;
        end
        if (!m_busy) begin
            if (wr_d) begin
                m_disp = wd[7:0]; m_busy = 1'b1; m_shown = 0;
            end
        end else if (m_shown + 1 == H) begin
            if (m_pv) begin
                m_disp  = m_pend;
                m_shown = 0;
                if (wr_d) m_pend = wd[7:0];
                else      m_pv = 1'b0;
            end else if (wr_d) begin
                m_disp = wd[7:0]; m_shown = 0;
            end else begin
                m_busy = 1'b0;
            end
        end else begin
            m_shown++;
            if (wr_d) begin
                set_ovr = m_pv;
                m_pend  = wd[7:0];
                m_pv    = 1'b1;
            end
        end
        if (set_ovr)                m_ovr = 1'b1;
        else if (wr_s && wd[2])     m_ovr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_disp"}, {24'b0, DisplayValue}, {24'b0, m_disp});
        chk({tag, "_busy"}, {31'b0, Busy}, {31'b0, m_busy});
        chk({tag, "_ovr"},  {31'b0, Overrun}, {31'b0, m_ovr});
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        Address  = PA + 32'd4;
        #1;
        chk({tag, "_rd_status"}, ReadData, {29'b0, m_ovr, m_pv, m_busy});
        Address = PA;
        #1;
        chk({tag, "_rd_data"}, ReadData, {24'b0, m_disp});
        MemRead = 1'b0;
        #1;
        chk({tag, "_rd_off"}, ReadData, 32'h0);
    endtask

    task automatic cyc(input string tag, input logic rst, input logic mw, input logic mr,
                       input logic [31:0] addr, input logic [31:0] wd);
        reset     = rst;
        MemWrite  = mw;
        MemRead   = mr;
        Address   = addr;
        WriteData = wd;
        @(posedge clk);
        model_step(rst, mw, addr, wd);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b0;
        check_all(tag);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wd);
        cyc(tag, 1'b0, 1'b1, 1'b0, addr, wd);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, PA, 32'h0);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        MemRead = 1'b1;
        Address = addr;
        #1;
        chk(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Address = '0; WriteData = '0;
        cyc("reset", 1'b1, 1'b0, 1'b0, PA, 32'h0);
        chk("reset_disp", {24'b0, DisplayValue}, 32'h0);
        chk("reset_busy", {31'b0, Busy}, 32'h0);

        // Scenario 1: single write, hold for exactly H cycles
        wr("t1_e0", PA, 32'h0000_002A);
        chk("t1_disp_e0", {24'b0, DisplayValue}, 32'h2A);
        idle("t1_hold", H - 1);
        chk("t1_busy_e3", {31'b0, Busy}, 32'h1);
        idle("t1_e4", 1);
        chk("t1_busy_e4", {31'b0, Busy}, 32'h0);
        chk("t1_disp_e4", {24'b0, DisplayValue}, 32'h2A);

        // Scenario 2: one pending value promoted at expiry
        wr("t2_e0", PA, 32'h11);
        wr("t2_e1", PA, 32'h22);
        idle("t2_e2e3", 2);
        chk("t2_disp_e3", {24'b0, DisplayValue}, 32'h11);
        idle("t2_e4", 1);
        chk("t2_disp_e4", {24'b0, DisplayValue}, 32'h22);
        read_chk("t2_status_e4", PA + 32'd4, 32'h1);
        idle("t2_e5e7", 3);
        idle("t2_e8", 1);
        chk("t2_busy_e8", {31'b0, Busy}, 32'h0);

        // Scenario 3: overrun, latest wins, status clear
        wr("t3_e0", PA, 32'h11);
        wr("t3_e1", PA, 32'h22);
        wr("t3_e2", PA, 32'h33);
        chk("t3_ovr_e2", {31'b0, Overrun}, 32'h1);
        read_chk("t3_status_e2", PA + 32'd4, 32'h7);
        idle("t3_e3", 1);
        idle("t3_e4", 1);
        chk("t3_disp_e4", {24'b0, DisplayValue}, 32'h33);
        wr("t3_clr", PA + 32'd4, 32'h4);
        chk("t3_ovr_clr", {31'b0, Overrun}, 32'h0);
        idle("t3_drain", 8);

        // Scenario 4: write coincident with expiry, nothing pending
        wr("t4_e0", PA, 32'h05);
        idle("t4_e1e3", 3);
        wr("t4_e4", PA, 32'h80);
        chk("t4_disp_e4", {24'b0, DisplayValue}, 32'h80);
        chk("t4_busy_e4", {31'b0, Busy}, 32'h1);
        idle("t4_e5e7", 3);
        chk("t4_disp_e7", {24'b0, DisplayValue}, 32'h80);
        idle("t4_e8", 1);
        chk("t4_busy_e8", {31'b0, Busy}, 32'h0);
        chk("t4_ovr", {31'b0, Overrun}, 32'h0);

        // Scenario 5: writes that must be ignored
        wr("t5_other", PA + 32'd8, 32'h55);
        cyc("t5_nowrite", 1'b0, 1'b0, 1'b0, PA, 32'h99);
        wr("t5_misalign", PA + 32'd1, 32'h77);
        chk("t5_disp", {24'b0, DisplayValue}, 32'h80);
        chk("t5_busy", {31'b0, Busy}, 32'h0);
        read_chk("t5_rd_other", PA + 32'd8, 32'h0);

        // Scenario 6: reset mid-hold discards the pending value
        wr("t6_e0", PA, 32'h11);
        wr("t6_e1", PA, 32'h22);
        cyc("t6_reset", 1'b1, 1'b0, 1'b0, PA, 32'h0);
        chk("t6_disp_rst", {24'b0, DisplayValue}, 32'h0);
        idle("t6_after", 6);
        chk("t6_disp_after", {24'b0, DisplayValue}, 32'h0);
        chk("t6_busy_after", {31'b0, Busy}, 32'h0);

        // Random bus traffic against the model
        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic [31:0] addr;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3, 4: addr = PA;
                5, 6:          addr = PA + 32'd4;
                7:             addr = PA + 32'd8;
                8:             addr = PA + 32'd1;
                default:       addr = $urandom;
            endcase
            cyc("rnd", ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1, addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
